board_ctrl: RTL and testbench

BOARD_CTRL -- requirements
Module: board_ctrl

---
 rtl/board_ctrl.sv | 146 ++++++++++++++
 tb/tb_board_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl.sv
// Board-game cell store with a wrapping cursor and black/white stone placement.
// A power-up/clear sweep zeroes one cell per cycle, and reads return empty while it runs.
module board_ctrl #(
  parameter int SIZE = 6,
  parameter int RW   = $clog2(SIZE),
  parameter int CW   = $clog2(SIZE*SIZE+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_place,
  input  logic          btn_clear,
  input  logic [RW-1:0] rd_row,
  input  logic [RW-1:0] rd_col,
  output logic [1:0]    rd_cell,
  output logic [RW-1:0] cursor_row,
  output logic [RW-1:0] cursor_col,
  output logic          turn,
  output logic [CW-1:0] move_cnt,
  output logic          board_full,
  output logic          place_ok,
  output logic          place_err,
  output logic          busy
);

  localparam int N  = SIZE*SIZE;
  localparam int IW = $clog2(N);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [RW-1:0] row_q, row_d, col_q, col_d;
  logic          turn_q, turn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ok_q, ok_d, err_q, err_d;

  logic [1:0]    board_q [N];
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [1:0]    wr_dat;
  logic [IW-1:0] cur_idx, rd_idx;
  logic [1:0]    cur_cell;

  assign cur_idx  = IW'(int'(row_q)*SIZE + int'(col_q));
  assign rd_idx   = IW'(int'(rd_row)*SIZE + int'(rd_col));
  assign cur_cell = board_q[cur_idx];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    turn_d  = turn_q;
    cnt_d   = cnt_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cur_idx;
    wr_dat  = 2'b00;
    if (state_q == S_CLEAR) begin
      // idx == N is one idle step after the last write before leaving the sweep
      if (btn_clear) begin
        idx_d = '0;
      end else if (idx_q == CW'(N)) begin
        state_d = S_IDLE;
      end else begin
        wr_en  = 1'b1;
        wr_idx = idx_q[IW-1:0];
        idx_d  = idx_q + CW'(1);
      end
    end else begin
      if (btn_clear) begin
        state_d = S_CLEAR;
        idx_d   = '0;
        cnt_d   = '0;
        turn_d  = 1'b0;
      end else if (btn_place) begin
        if (cur_cell == 2'b00) begin
          wr_en  = 1'b1;
          wr_dat = turn_q ? 2'b10 : 2'b01;
          turn_d = ~turn_q;
          if (cnt_q != CW'(N)) cnt_d = cnt_q + CW'(1);
          ok_d   = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
      end else begin
        if (btn_up && !btn_down)
          row_d = (row_q == '0) ? RW'(SIZE-1) : row_q - RW'(1);
        else if (btn_down && !btn_up)
          row_d = (row_q == RW'(SIZE-1)) ? '0 : row_q + RW'(1);
        if (btn_left && !btn_right)
          col_d = (col_q == '0) ? RW'(SIZE-1) : col_q - RW'(1);
        else if (btn_right && !btn_left)
          col_d = (col_q == RW'(SIZE-1)) ? '0 : col_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      turn_q  <= 1'b0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      turn_q  <= turn_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // Cell storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (wr_en) board_q[wr_idx] <= wr_dat;
  end

  always_comb begin
    rd_cell = 2'b00;
    if (!busy && int'(rd_row) < SIZE && int'(rd_col) < SIZE)
      rd_cell = board_q[rd_idx];
  end

  assign busy       = (state_q == S_CLEAR);
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign turn       = turn_q;
  assign move_cnt   = cnt_q;
  assign board_full = (cnt_q == CW'(N));
  assign place_ok   = ok_q;
  assign place_err  = err_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: a 6x6 instance for sweep/cursor/placement/clear
// and a 2x2 instance for board-full behaviour.
module tb_board_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, left, right, place, clear;
  logic [2:0] rd_row, rd_col;
  logic [1:0] rd_cell;
  logic [2:0] cur_row, cur_col;
  logic       turn, full, ok, err, busy;
  logic [5:0] cnt;

  logic       b_up, b_down, b_left, b_right, b_place, b_clear;
  logic [0:0] b_rd_row, b_rd_col;
  logic [1:0] b_rd_cell;
  logic [0:0] b_cur_row, b_cur_col;
  logic       b_turn, b_full, b_ok, b_err, b_busy;
  logic [2:0] b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  board_ctrl #(.SIZE(6)) dut6 (
    .clk(clk), .rst(rst),
    .btn_up(up), .btn_down(down), .btn_left(left), .btn_right(right),
    .btn_place(place), .btn_clear(clear),
    .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell),
    .cursor_row(cur_row), .cursor_col(cur_col),
    .turn(turn), .move_cnt(cnt), .board_full(full),
    .place_ok(ok), .place_err(err), .busy(busy)
  );

  board_ctrl #(.SIZE(2)) dut2 (
    .clk(clk), .rst(rst),
    .btn_up(b_up), .btn_down(b_down), .btn_left(b_left), .btn_right(b_right),
    .btn_place(b_place), .btn_clear(b_clear),
    .rd_row(b_rd_row), .rd_col(b_rd_col), .rd_cell(b_rd_cell),
    .cursor_row(b_cur_row), .cursor_col(b_cur_col),
    .turn(b_turn), .move_cnt(b_cnt), .board_full(b_full),
    .place_ok(b_ok), .place_err(b_err), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs then released and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    {up, down, left, right, place, clear} = '0;
    {b_up, b_down, b_left, b_right, b_place, b_clear} = '0;
  endtask

  task automatic rd6(input int r, input int c);
    rd_row = 3'(r);
    rd_col = 3'(c);
    #1;
  endtask

  task automatic rd2(input int r, input int c);
    b_rd_row = 1'(r);
    b_rd_col = 1'(c);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int bad;
    rst = 1'b1;
    {up, down, left, right, place, clear} = '0;
    {b_up, b_down, b_left, b_right, b_place, b_clear} = '0;
    rd_row = '0; rd_col = '0; b_rd_row = '0; b_rd_col = '0;
    step(); step();

    chk("rst_busy", busy, 1);
    chk("rst_row", cur_row, 0);
    chk("rst_col", cur_col, 0);
    chk("rst_turn", turn, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ok_err", {ok, err}, 0);

    // Sweep: busy high after each of 36 edges, low after the 37th
    rst = 1'b0;
    hi = 0;
    for (int k = 0; k < 36; k++) begin
      step();
      if (busy) hi++;
    end
    chk("sweep_busy_cycles", hi, 36);
    step();
    chk("sweep_busy_fall", busy, 0);
    bad = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        rd6(r, c);
        if (rd_cell !== 2'b00) bad++;
      end
    chk("sweep_all_empty", bad, 0);
    chk("sweep_cnt", cnt, 0);
    chk("sweep_turn", turn, 0);

    // Cursor wrap and conflicting buttons
    up = 1; step();
    chk("up_wrap_row", cur_row, 5);
    left = 1; step();
    chk("left_wrap_col", cur_col, 5);
    down = 1; step();
    chk("down_wrap_row", cur_row, 0);
    right = 1; step();
    chk("right_wrap_col", cur_col, 0);
    up = 1; left = 1; step();
    chk("diag_move", {cur_row, cur_col}, {3'd5, 3'd5});
    up = 1; down = 1; step();
    chk("up_down_cancel", cur_row, 5);
    down = 1; left = 1; right = 1; step();
    chk("lr_cancel_down", {cur_row, cur_col}, {3'd0, 3'd5});
    down = 1; left = 1; step();
    down = 1; left = 1; step();
    chk("cursor_2_3", {cur_row, cur_col}, {3'd2, 3'd3});

    // Place at (2,3); read of the same cell before the edge sees old value
    rd6(2, 3);
    place = 1;
    #1;
    chk("no_bypass", rd_cell, 2'b00);
    step();
    chk("place1_ok_err", {ok, err}, 2'b10);
    chk("place1_cell", rd_cell, 2'b01);
    chk("place1_turn", turn, 1);
    chk("place1_cnt", cnt, 1);
    step();
    chk("ok_one_cycle", ok, 0);
    place = 1; step();
    chk("place2_ok_err", {ok, err}, 2'b01);
    chk("place2_cell", rd_cell, 2'b01);
    chk("place2_turn", turn, 1);
    chk("place2_cnt", cnt, 1);
    step();
    chk("err_one_cycle", err, 0);

    // Place beats a simultaneous cursor move
    up = 1; right = 1; step();
    up = 1; right = 1; step();
    right = 1; step();
    chk("cursor_home", {cur_row, cur_col}, {3'd0, 3'd0});
    place = 1; right = 1; step();
    chk("pri_place_ok", ok, 1);
    chk("pri_cursor", {cur_row, cur_col}, {3'd0, 3'd0});
    rd6(0, 0);
    chk("pri_cell_white", rd_cell, 2'b10);
    chk("pri_turn", turn, 0);
    chk("pri_cnt", cnt, 2);
    rd6(6, 0);
    chk("rd_row_oob", rd_cell, 2'b00);
    rd6(7, 7);
    chk("rd_both_oob", rd_cell, 2'b00);

    // Clear from IDLE, buttons ignored while sweeping, restart mid-sweep
    rd6(0, 0);
    clear = 1; step();
    chk("clr_busy", busy, 1);
    chk("clr_cnt", cnt, 0);
    chk("clr_turn", turn, 0);
    chk("clr_rd_gated", rd_cell, 2'b00);
    step(); step();
    place = 1; up = 1; step();
    chk("clr_ignore_cursor", cur_row, 0);
    chk("clr_ignore_place", {ok, err}, 2'b00);
    for (int k = 0; k < 5; k++) step();
    clear = 1; step();
    hi = 0;
    for (int k = 0; k < 36; k++) begin
      step();
      if (busy) hi++;
    end
    chk("restart_busy_cycles", hi, 36);
    step();
    chk("restart_busy_fall", busy, 0);
    rd6(0, 0);
    chk("restart_cell_0_0", rd_cell, 2'b00);
    rd6(2, 3);
    chk("restart_cell_2_3", rd_cell, 2'b00);

    // 2x2 board fill
    chk("b_idle", b_busy, 0);
    b_place = 1; step();
    b_right = 1; step();
    b_place = 1; step();
    b_down = 1; step();
    b_place = 1; step();
    b_left = 1; step();
    chk("b_not_full", b_full, 0);
    b_place = 1; step();
    chk("b_full", b_full, 1);
    chk("b_cnt4", b_cnt, 4);
    rd2(0, 0); chk("b_cell00", b_rd_cell, 2'b01);
    rd2(0, 1); chk("b_cell01", b_rd_cell, 2'b10);
    rd2(1, 1); chk("b_cell11", b_rd_cell, 2'b01);
    rd2(1, 0); chk("b_cell10", b_rd_cell, 2'b10);
    b_place = 1; step();
    chk("b_fifth_err", {b_ok, b_err}, 2'b01);
    chk("b_cnt_sat", b_cnt, 4);

    // Asynchronous reset right after a placement
    down = 1; step();
    place = 1; step();
    chk("pre_rst_ok", ok, 1);
    chk("pre_rst_turn", turn, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ok", ok, 0);
    chk("arst_turn", turn, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_busy", busy, 1);
    chk("arst_cursor", {cur_row, cur_col}, 6'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
